// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the sequential shift unit: state and op encodings
// plus default widths.
package seq_shift_unit_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int SHAMT_W_DEF = 5;

   localparam logic OP_SLL = 1'b0;
   localparam logic OP_SRA = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_shift_unit_shift_one_step.sv
// Combinational single-bit shifter: SLL fills zero at bit 0, SRA replicates
// the sign bit.
module shift_one_step
   import seq_shift_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              op,
   input  logic [DATA_W-1:0] value,
   output logic [DATA_W-1:0] result
);

   assign result = (op == OP_SRA) ? {value[DATA_W-1], value[DATA_W-1:1]}
                                  : {value[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit per clock in SHIFT, result presented with a
// single-cycle data_resultRDY pulse in DONE.
module seq_shift_unit
   import seq_shift_unit_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ctrl_shift,
   input  logic               op,
   input  logic [DATA_W-1:0]  data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [DATA_W-1:0]  data_out,
   output logic               data_resultRDY,
   output logic               busy
);

   if (DATA_W != (2 ** SHAMT_W)) begin : g_bad_width
      $error("seq_shift_unit: DATA_W must equal 2**SHAMT_W");
   end

   state_t               state_reg, state_next;
   logic [SHAMT_W-1:0]   cnt_reg;
   logic [DATA_W-1:0]    work_reg;
   logic                 op_reg;
   logic [DATA_W-1:0]    data_out_reg;
   logic [DATA_W-1:0]    step_value;
   logic                 load;
   logic                 step_en;
   logic                 last_step;

   shift_one_step #(.DATA_W(DATA_W)) u_step (
      .op     (op_reg),
      .value  (work_reg),
      .result (step_value)
   );

   assign last_step = (cnt_reg == SHAMT_W'(1));

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step_en    = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            // DONE accepts a new start directly so operations can run back-to-back
            if (ctrl_shift) begin
               load       = 1'b1;
               state_next = (shamt != '0) ? SHIFT : DONE;
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            step_en = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         work_reg     <= '0;
         op_reg       <= OP_SLL;
         data_out_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (load) begin
            work_reg <= data_in;
            op_reg   <= op;
            cnt_reg  <= shamt;
            if (shamt == '0) begin
               data_out_reg <= data_in;
            end
         end else if (step_en) begin
            work_reg <= step_value;
            cnt_reg  <= cnt_reg - SHAMT_W'(1);
            // Output register only changes when a result is produced, so it holds otherwise
            if (last_step) begin
               data_out_reg <= step_value;
            end
         end
      end
   end

   assign data_out       = data_out_reg;
   assign data_resultRDY = (state_reg == DONE);
   assign busy           = (state_reg == SHIFT);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: stimulus pushes expected results,
// a negedge monitor checks value, latency and busy duration per pulse.
module tb_seq_shift_unit;
   import seq_shift_unit_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_shift = 1'b0;
   logic        op = 1'b0;
   logic [31:0] data_in = 32'h0;
   logic [4:0]  shamt = 5'd0;
   logic [31:0] data_out;
   logic        data_resultRDY;
   logic        busy;

   seq_shift_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_shift     (ctrl_shift),
      .op             (op),
      .data_in        (data_in),
      .shamt          (shamt),
      .data_out       (data_out),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      int          busy;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        rst_seen = 1'b1;
   logic [31:0] hold_val = 32'h0;
   int          busy_cnt = 0;

   always @(posedge clock) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   // Monitor: every negedge checks output hold, and on a pulse pops the scoreboard
   always @(negedge clock) begin
      if (rst_seen) begin
         hold_val = 32'h0;
         busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: data_out=%h at cycle %0d, no result pending", data_out, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (data_out !== mon_e.data) begin
               errors++;
               $display("FAIL %s_data: got %h expected %h", mon_e.name, data_out, mon_e.data);
            end
            checks++;
            if (cyc != mon_e.cyc) begin
               errors++;
               $display("FAIL %s_latency: pulse at cycle %0d expected cycle %0d", mon_e.name, cyc, mon_e.cyc);
            end
            checks++;
            if (busy_cnt != mon_e.busy || busy !== 1'b0) begin
               errors++;
               $display("FAIL %s_busy: busy cycles %0d (busy now %b) expected %0d (busy now 0)",
                        mon_e.name, busy_cnt, busy, mon_e.busy);
            end
            $display("txn %s: data_out=%h cycle=%0d busy_cycles=%0d", mon_e.name, data_out, cyc, busy_cnt);
            hold_val = mon_e.data;
         end
         busy_cnt = 0;
      end else begin
         checks++;
         if (data_out !== hold_val) begin
            errors++;
            $display("FAIL hold: data_out=%h expected %h at cycle %0d", data_out, hold_val, cyc);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; start is sampled on the following posedge
   task automatic start(input logic o, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] exp, input string nm, input bit push);
      ctrl_shift = 1'b1;
      op         = o;
      data_in    = d;
      shamt      = s;
      if (push) begin
         exp_t e;
         e.data = exp;
         e.cyc  = cyc + 1 + int'(s);
         e.busy = int'(s);
         e.name = nm;
         sb.push_back(e);
      end
      @(negedge clock);
      ctrl_shift = 1'b0;
      op         = 1'($urandom);
      data_in    = $urandom;
      shamt      = 5'($urandom);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d results pending, required 0", nm, sb.size());
         sb.delete();
      end
      @(negedge clock);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      check("reset_data_out", data_out, 32'h0);
      check("reset_rdy", {31'h0, data_resultRDY}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);

      reset = 1'b0;
      start(OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra_sign_31", 1'b1);
      drain("sra_sign_31");

      start(OP_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, "sll_1_by_4", 1'b1);
      drain("sll_1_by_4");

      start(OP_SLL, 32'h1234_5678, 5'd0, 32'h1234_5678, "sll_zero", 1'b1);
      drain("sll_zero");
      start(OP_SRA, 32'h1234_5678, 5'd0, 32'h1234_5678, "sra_zero", 1'b1);
      drain("sra_zero");

      start(OP_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, "sll_ones_31", 1'b1);
      drain("sll_ones_31");
      start(OP_SRA, 32'h4000_0000, 5'd30, 32'h0000_0001, "sra_pos_30", 1'b1);
      drain("sra_pos_30");
      start(OP_SLL, 32'hA5A5_A5A5, 5'd8, 32'hA5A5_A500, "sll_a5_8", 1'b1);
      drain("sll_a5_8");
      start(OP_SRA, 32'h8000_1234, 5'd16, 32'hFFFF_8000, "sra_neg_16", 1'b1);
      drain("sra_neg_16");

      // Second start while shifting must be ignored
      start(OP_SRA, 32'h7FFF_FFF0, 5'd4, 32'h07FF_FFFF, "sra_ignore", 1'b1);
      ctrl_shift = 1'b1;
      op         = OP_SLL;
      data_in    = 32'hFFFF_FFFF;
      shamt      = 5'd3;
      @(negedge clock);
      ctrl_shift = 1'b0;
      drain("sra_ignore");

      // Reset mid-shift aborts without a pulse
      start(OP_SLL, 32'h0000_00FF, 5'd10, 32'h0, "abort", 1'b0);
      repeat (3) @(negedge clock);
      check("abort_busy_before", {31'h0, busy}, 32'h1);
      reset = 1'b1;
      @(negedge clock);
      check("abort_data_out", data_out, 32'h0);
      check("abort_rdy", {31'h0, data_resultRDY}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      repeat (15) @(negedge clock);

      // Back-to-back start taken in the DONE cycle
      start(OP_SLL, 32'h0000_0001, 5'd1, 32'h0000_0002, "b2b_first", 1'b1);
      @(negedge clock);
      check("b2b_in_done", {31'h0, data_resultRDY}, 32'h1);
      start(OP_SRA, 32'hF000_0000, 5'd2, 32'hFC00_0000, "b2b_second", 1'b1);
      drain("b2b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width.
REQ-002 SHALL have parameter SHAMT_W, default 5: shift-amount width; DATA_W SHALL equal 2**SHAMT_W.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-005 SHALL have port ctrl_shift  input  1  start request; sampled high on a clock edge.
REQ-006 SHALL have port op  input  1  0 = logical left shift (SLL); 1 = arithmetic right shift (SRA).
REQ-007 SHALL have port data_in  input  DATA_W  operand, sampled with ctrl_shift.
REQ-008 SHALL have port shamt  input  SHAMT_W  shift amount, unsigned, sampled with ctrl_shift.
REQ-009 SHALL have port data_out  output  DATA_W  result register.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE or DONE, ctrl_shift=1 SHALL latch data_in, op and shamt into the working register and counter.
REQ-014 On that same edge, the FSM SHALL enter SHIFT if shamt!=0, else DONE.
REQ-015 In SHIFT, each cycle SHALL apply exactly one 1-bit step to the working register and decrement the counter.
- SLL: zero fill at bit 0.
- SRA: bit DATA_W-1 replicated.
REQ-016 SHIFT SHALL exit to DONE on the edge where the counter goes from 1 to 0.
REQ-017 Latency: with start sampled at edge T0, data_resultRDY SHALL be high in the cycle after edge T0+shamt, i.e. shamt+1 edges after start (shamt=0 gives 1 edge).
REQ-018 data_resultRDY SHALL be high only in state DONE, for exactly one cycle per operation.
REQ-019 data_out SHALL be valid in the DONE cycle and SHALL hold its value until the next DONE or reset.
REQ-020 DONE SHALL go to IDLE next edge unless ctrl_shift=1, in which case a new operation SHALL start per REQ-013/014 (back-to-back).
REQ-021 busy SHALL be high in SHIFT and low in IDLE and DONE.
REQ-022 ctrl_shift asserted while in SHIFT SHALL be ignored; in-flight op, data_in and shamt capture SHALL be unaffected.
REQ-023 Changes on data_in, op and shamt outside a start edge SHALL not affect the result.
REQ-024 Results SHALL be bit-exact to Verilog data_in << shamt (SLL) or $signed(data_in) >>> shamt (SRA).

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, counter=0, working register=0, data_out=0, data_resultRDY=0, busy=0.
REQ-026 reset SHALL take priority over ctrl_shift and SHALL abort any in-flight operation without a result pulse.
REQ-027 The first start SHALL be accepted on the first edge with reset=0 and ctrl_shift=1.

Structure
REQ-028 A shared package SHALL hold:
- state encoding (IDLE/SHIFT/DONE);
- op encoding constants OP_SLL=0, OP_SRA=1;
- default DATA_W and SHAMT_W.
REQ-029 The one-step datapath SHALL be a combinational sub-module shift_one_step: inputs op and value, output value shifted by one bit per REQ-015.
REQ-030 The FSM, counter, working register and output register SHALL reside in seq_shift_unit.

Verification
REQ-031 SRA, data_in=0x80000000, shamt=31 -> data_out=0xFFFFFFFF, data_resultRDY 32 edges after start, busy high 31 cycles.
REQ-032 SLL, data_in=0x00000001, shamt=4 -> data_out=0x00000010, data_resultRDY 5 edges after start.
REQ-033 shamt=0, data_in=0x12345678, either op -> data_out=0x12345678, data_resultRDY 1 edge after start, busy never high.
REQ-034 SRA 0x7FFFFFF0 by 4, second ctrl_shift with data_in=0xFFFFFFFF during SHIFT -> data_out=0x07FFFFFF, single pulse.
REQ-035 reset asserted mid-SHIFT -> next cycle all outputs 0, state IDLE, no data_resultRDY pulse.
REQ-036 ctrl_shift in DONE cycle (SLL 0x1 by 1, then SRA 0xF0000000 by 2) -> results 0x2 then 0xFC000000, pulses 3 edges apart.
